mainbus_sequencer: RTL and testbench
====================================

Name: mainbus_sequencer

Overview:
Parametrised, registered successor to the main-bus control decoder. It takes the encoded bus, transfer and address select fields from the pipeline control stage and drives one-hot assert/load/addr enables one cycle later. It inserts memory wait states with an ack handshake and timeout, and detects illegal self-transfer contention. It sits between the pipeline control ROM stage and the register file, memory bridge and pointer registers.

Parameters:
DEV_W, 4, width of main-bus assert/load device codes (2**DEV_W devices; code 0 = none)
XFER_W, 3, width of transfer-bus assert and load/dec codes (code 0 = none)
ADDR_W, 3, width of address-select code (code 0 = none)
MEM_DEV, 8, main-bus device code of the memory bridge
TIMEOUT_CYCLES, 16, maximum wait cycles before a forced exit; range 2..255

Ports:
clk  in  1  system clock, rising edge
reset_in  in  1  asynchronous active-low reset
op_valid  in  1  control fields valid this cycle
bus_assert_sel  in  DEV_W  main-bus assert device code
bus_load_sel  in  DEV_W  main-bus load device code
xfer_assert_sel  in  XFER_W  transfer-bus assert code
xfer_load_sel  in  XFER_W  transfer-bus load/dec code
addr_sel  in  ADDR_W  address-bus source code
mem_ack  in  1  memory bridge completes access
stall  out  1  pipeline hold; op not accepted while high
bus_assert_oh  out  2**DEV_W  one-hot main-bus assert enables (bit 0 always 0)
bus_load_oh  out  2**DEV_W  one-hot main-bus load enables (bit 0 always 0)
xfer_assert_oh  out  2**XFER_W  one-hot transfer assert enables
xfer_load_oh  out  2**XFER_W  one-hot transfer load/dec enables
addr_oh  out  2**ADDR_W  one-hot address assert enables
mem_dir  out  1  1 = memory read (bridge asserts), 0 = write
timeout_err  out  1  sticky: a memory wait hit timeout
contention_err  out  1  sticky: illegal op dropped

Behaviour:
- Reset: all outputs 0, FSM in IDLE, wait counter 0. Sticky flags are cleared only by reset.
- FSM has three states: IDLE, ACTIVE, MEM_WAIT.
- Acceptance: an op is accepted when op_valid && !stall. Its decoded one-hots are registered and appear on the next rising edge (latency 1).
- No op accepted: all one-hots go to 0 on the next edge. State becomes IDLE unless in MEM_WAIT.
- Memory op: bus_assert_sel==MEM_DEV or bus_load_sel==MEM_DEV.
  - An accepted memory op enters MEM_WAIT and clears the wait counter.
  - mem_dir = (bus_assert_sel==MEM_DEV), registered with the op.
  - A non-memory op goes to ACTIVE.
- MEM_WAIT:
  - One-hots and mem_dir hold their values.
  - stall = !mem_ack, combinational from state and mem_ack.
  - The counter increments each cycle without ack.
- On mem_ack in MEM_WAIT: stall is low that cycle, so a new op may be accepted. The next edge loads the new op's decode, or zeros if none, and transitions to MEM_WAIT, ACTIVE or IDLE accordingly.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 without ack:
  - timeout_err sets.
  - stall drops that cycle.
  - Exit proceeds exactly as with ack.
- Simultaneous ack and timeout: treated as ack; timeout_err is not set.
- Contention: an op with bus_assert_sel==bus_load_sel!=0, or xfer_assert_sel==xfer_load_sel!=0, is dropped. All one-hots go to 0 next edge, contention_err sets, and the state goes to IDLE. This rule has priority over memory detection.
- mem_ack outside MEM_WAIT is ignored.
- Reset asserted mid-wait: immediate return to the reset values; stall drops asynchronously.
- Code 0 in any field means that field's one-hot is all zeros; other fields still decode.

Optional Feature:
MAINBUS_WAITSTAT_EN
- Defined:
  - Adds output last_wait_cycles [7:0], loaded with the wait count on each MEM_WAIT exit (ack or timeout), reset 0.
  - Adds output wait_hist_sat [7:0], a saturating count of timeouts, reset 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mainbus_pkg:
  - state enum {IDLE, ACTIVE, MEM_WAIT}
  - default width constants
  - device code constants (NONE=0, MEM_DEV=8)
- Sub-module onehot_dec (parameter W): code in, 2**W one-hot out, code 0 gives all zeros. It is instantiated five times.

Test Plan:
- Reset then op bus_assert_sel=2, bus_load_sel=5, op_valid 1 cycle -> next cycle bus_assert_oh=0x0004, bus_load_oh=0x0020, stall=0; following cycle all zeros, state IDLE.
- Op bus_assert_sel=8 (memory read), mem_ack asserted 3 cycles later -> one-hots held for 4 cycles, stall high 3 cycles, mem_dir=1, exit on ack edge.
- Memory write op, no ack -> stall high 15 cycles, timeout_err=1 in cycle 16, outputs cleared next edge (last_wait_cycles=15 if MAINBUS_WAITSTAT_EN).
- Op bus_assert_sel=bus_load_sel=3 -> all one-hots 0 next edge, contention_err=1 sticky across later legal ops.
- Back-to-back: memory op, then on the ack cycle a non-memory op (xfer_assert_sel=1, addr_sel=4) -> next edge xfer_assert_oh=0x02, addr_oh=0x10, state ACTIVE.
- reset_in low mid-MEM_WAIT -> stall and all outputs 0 immediately; after release, idle until the next op.

Source files
------------

// File: rtl/mainbus_pkg.sv
// Shared state encoding, default widths and device codes for the main-bus sequencer.
package mainbus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int DEV_W_DEF   = 4;
    localparam int XFER_W_DEF  = 3;
    localparam int ADDR_W_DEF  = 3;
    localparam int TIMEOUT_DEF = 16;
    localparam int WAIT_CNT_W  = 8;

    localparam int CODE_NONE = 0;
    localparam int DEV_MEM   = 8;

endpackage

// File: rtl/onehot_dec.sv
// Binary code to one-hot decoder; code 0 selects nothing, so bit 0 never sets.
module onehot_dec #(
    parameter int W = 3
) (
    input  logic [W-1:0]        code_i,
    output logic [(2**W)-1:0]   oh_o
);

    always_comb begin
        oh_o = '0;
        if (code_i != '0) begin
            oh_o[code_i] = 1'b1;
        end
    end

endmodule

// File: rtl/mainbus_sequencer.sv
// Registered main-bus control decoder with memory wait states, timeout and contention detection.
// Optional MAINBUS_WAITSTAT_EN adds last_wait_cycles and wait_hist_sat statistics outputs.
module mainbus_sequencer
    import mainbus_pkg::*;
#(
    parameter int DEV_W          = DEV_W_DEF,
    parameter int XFER_W         = XFER_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int MEM_DEV        = DEV_MEM,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset_in,
    input  logic                     op_valid,
    input  logic [DEV_W-1:0]         bus_assert_sel,
    input  logic [DEV_W-1:0]         bus_load_sel,
    input  logic [XFER_W-1:0]        xfer_assert_sel,
    input  logic [XFER_W-1:0]        xfer_load_sel,
    input  logic [ADDR_W-1:0]        addr_sel,
    input  logic                     mem_ack,
    output logic                     stall,
    output logic [(2**DEV_W)-1:0]    bus_assert_oh,
    output logic [(2**DEV_W)-1:0]    bus_load_oh,
    output logic [(2**XFER_W)-1:0]   xfer_assert_oh,
    output logic [(2**XFER_W)-1:0]   xfer_load_oh,
    output logic [(2**ADDR_W)-1:0]   addr_oh,
    output logic                     mem_dir,
    output logic                     timeout_err,
    output logic                     contention_err
`ifdef MAINBUS_WAITSTAT_EN
    ,
    output logic [7:0]               last_wait_cycles,
    output logic [7:0]               wait_hist_sat
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [(2**DEV_W)-1:0]  ba_dec, bl_dec;
    logic [(2**XFER_W)-1:0] xa_dec, xl_dec;
    logic [(2**ADDR_W)-1:0] ad_dec;

    onehot_dec #(.W(DEV_W))  u_dec_ba (.code_i(bus_assert_sel),  .oh_o(ba_dec));
    onehot_dec #(.W(DEV_W))  u_dec_bl (.code_i(bus_load_sel),    .oh_o(bl_dec));
    onehot_dec #(.W(XFER_W)) u_dec_xa (.code_i(xfer_assert_sel), .oh_o(xa_dec));
    onehot_dec #(.W(XFER_W)) u_dec_xl (.code_i(xfer_load_sel),   .oh_o(xl_dec));
    onehot_dec #(.W(ADDR_W)) u_dec_ad (.code_i(addr_sel),        .oh_o(ad_dec));

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [(2**DEV_W)-1:0]   ba_q, ba_d, bl_q, bl_d;
    logic [(2**XFER_W)-1:0]  xa_q, xa_d, xl_q, xl_d;
    logic [(2**ADDR_W)-1:0]  ad_q, ad_d;
    logic                    dir_q, dir_d;
    logic                    terr_q, terr_d;
    logic                    cerr_q, cerr_d;

    logic in_wait, at_limit, ack_exit, to_exit, accept, is_contend, is_mem;

    assign in_wait  = (state_q == MEM_WAIT);
    assign at_limit = (cnt_q == TO_LAST);
    assign ack_exit = in_wait && mem_ack;
    // A simultaneous ack wins over the timeout, so only an un-acked limit counts as one.
    assign to_exit  = in_wait && !mem_ack && at_limit;
    assign stall    = in_wait && !mem_ack && !at_limit;
    assign accept   = op_valid && !stall;

    assign is_contend = ((bus_assert_sel == bus_load_sel) &&
                         (bus_assert_sel != DEV_W'(CODE_NONE))) ||
                        ((xfer_assert_sel == xfer_load_sel) &&
                         (xfer_assert_sel != XFER_W'(CODE_NONE)));
    assign is_mem     = (bus_assert_sel == DEV_W'(MEM_DEV)) ||
                        (bus_load_sel == DEV_W'(MEM_DEV));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ba_d    = ba_q;
        bl_d    = bl_q;
        xa_d    = xa_q;
        xl_d    = xl_q;
        ad_d    = ad_q;
        dir_d   = dir_q;
        terr_d  = terr_q | to_exit;
        cerr_d  = cerr_q;
        if (stall) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
            ba_d    = '0;
            bl_d    = '0;
            xa_d    = '0;
            xl_d    = '0;
            ad_d    = '0;
            dir_d   = 1'b0;
            if (accept) begin
                if (is_contend) begin
                    cerr_d = 1'b1;
                end else begin
                    ba_d    = ba_dec;
                    bl_d    = bl_dec;
                    xa_d    = xa_dec;
                    xl_d    = xl_dec;
                    ad_d    = ad_dec;
                    dir_d   = (bus_assert_sel == DEV_W'(MEM_DEV));
                    state_d = is_mem ? MEM_WAIT : ACTIVE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ba_q    <= '0;
            bl_q    <= '0;
            xa_q    <= '0;
            xl_q    <= '0;
            ad_q    <= '0;
            dir_q   <= 1'b0;
            terr_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ba_q    <= ba_d;
            bl_q    <= bl_d;
            xa_q    <= xa_d;
            xl_q    <= xl_d;
            ad_q    <= ad_d;
            dir_q   <= dir_d;
            terr_q  <= terr_d;
            cerr_q  <= cerr_d;
        end
    end

    assign bus_assert_oh  = ba_q;
    assign bus_load_oh    = bl_q;
    assign xfer_assert_oh = xa_q;
    assign xfer_load_oh   = xl_q;
    assign addr_oh        = ad_q;
    assign mem_dir        = dir_q;
    assign timeout_err    = terr_q;
    assign contention_err = cerr_q;

`ifdef MAINBUS_WAITSTAT_EN
    logic [7:0] last_q, last_d;
    logic [7:0] hist_q, hist_d;

    always_comb begin
        last_d = last_q;
        hist_d = hist_q;
        if (ack_exit || to_exit) begin
            last_d = cnt_q;
        end
        if (to_exit && (hist_q != 8'hFF)) begin
            hist_d = hist_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            last_q <= '0;
            hist_q <= '0;
        end else begin
            last_q <= last_d;
            hist_q <= hist_d;
        end
    end

    assign last_wait_cycles = last_q;
    assign wait_hist_sat    = hist_q;
`else
    logic unused_ack_exit;
    assign unused_ack_exit = ack_exit;
`endif

endmodule

// File: tb/tb_mainbus_sequencer.sv
// Scoreboard bench for mainbus_sequencer: a transaction-level model predicts each cycle's outputs.
module tb_mainbus_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        op_valid;
    logic [3:0]  bus_assert_sel, bus_load_sel;
    logic [2:0]  xfer_assert_sel, xfer_load_sel, addr_sel;
    logic        mem_ack;
    logic        stall;
    logic [15:0] bus_assert_oh, bus_load_oh;
    logic [7:0]  xfer_assert_oh, xfer_load_oh, addr_oh;
    logic        mem_dir, timeout_err, contention_err;
`ifdef MAINBUS_WAITSTAT_EN
    logic [7:0]  last_wait_cycles, wait_hist_sat;
`endif

    mainbus_sequencer dut (
        .clk(clk), .reset_in(reset_in), .op_valid(op_valid),
        .bus_assert_sel(bus_assert_sel), .bus_load_sel(bus_load_sel),
        .xfer_assert_sel(xfer_assert_sel), .xfer_load_sel(xfer_load_sel),
        .addr_sel(addr_sel), .mem_ack(mem_ack), .stall(stall),
        .bus_assert_oh(bus_assert_oh), .bus_load_oh(bus_load_oh),
        .xfer_assert_oh(xfer_assert_oh), .xfer_load_oh(xfer_load_oh),
        .addr_oh(addr_oh), .mem_dir(mem_dir), .timeout_err(timeout_err),
        .contention_err(contention_err)
`ifdef MAINBUS_WAITSTAT_EN
        , .last_wait_cycles(last_wait_cycles), .wait_hist_sat(wait_hist_sat)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected view of the block during one cycle.
    typedef struct packed {
        logic        stall;
        logic [15:0] ba, bl;
        logic [7:0]  xa, xl, ad;
        logic        dir, terr, cerr;
        logic [7:0]  last, hist;
    } exp_t;

    exp_t exp_q[$];

    // Model: the currently presented transfer, whether it is a pending memory access,
    // how many cycles it has waited, and the sticky/statistics history.
    logic [15:0] m_ba, m_bl;
    logic [7:0]  m_xa, m_xl, m_ad;
    logic        m_dir, m_terr, m_cerr, m_pending;
    int          m_waited, m_last, m_hist;

    function automatic logic [31:0] onehot(input int code);
        return (code == 0) ? 32'd0 : (32'd1 << code);
    endfunction

    task automatic model_reset();
        m_ba = 0; m_bl = 0; m_xa = 0; m_xl = 0; m_ad = 0;
        m_dir = 0; m_terr = 0; m_cerr = 0; m_pending = 0;
        m_waited = 0; m_last = 0; m_hist = 0;
    endtask

    task automatic drive(input bit v, input int ba, input int bl, input int xa,
                         input int xl, input int ad, input bit ack);
        exp_t e;
        bit   hold;
        @(posedge clk);
        #2;
        op_valid = v; bus_assert_sel = 4'(ba); bus_load_sel = 4'(bl);
        xfer_assert_sel = 3'(xa); xfer_load_sel = 3'(xl); addr_sel = 3'(ad); mem_ack = ack;
        hold = m_pending && !ack && (m_waited < TO - 1);
        e = '{stall: hold, ba: m_ba, bl: m_bl, xa: m_xa, xl: m_xl, ad: m_ad,
              dir: m_dir, terr: m_terr, cerr: m_cerr, last: 8'(m_last), hist: 8'(m_hist)};
        exp_q.push_back(e);
        if (hold) begin
            m_waited++;
        end else begin
            if (m_pending) begin
                m_last = m_waited;
                if (!ack) begin
                    m_terr = 1;
                    if (m_hist < 255) m_hist++;
                end
            end
            m_ba = 0; m_bl = 0; m_xa = 0; m_xl = 0; m_ad = 0; m_dir = 0;
            m_pending = 0; m_waited = 0;
            if (v) begin
                if ((ba == bl && ba != 0) || (xa == xl && xa != 0)) begin
                    m_cerr = 1;
                end else begin
                    m_ba = 16'(onehot(ba)); m_bl = 16'(onehot(bl));
                    m_xa = 8'(onehot(xa));  m_xl = 8'(onehot(xl)); m_ad = 8'(onehot(ad));
                    m_dir = (ba == 8);
                    m_pending = (ba == 8) || (bl == 8);
                end
            end
        end
    endtask

    task automatic idle(input bit ack);
        drive(0, 0, 0, 0, 0, 0, ack);
    endtask

    task automatic look();
        #4;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_oh"}, 32'(|{bus_assert_oh, bus_load_oh, xfer_assert_oh, xfer_load_oh, addr_oh}), 0);
        chk({tag, "_flags"}, 32'({mem_dir, timeout_err, contention_err}), 0);
`ifdef MAINBUS_WAITSTAT_EN
        chk({tag, "_stats"}, 32'({last_wait_cycles, wait_hist_sat}), 0);
`endif
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        reset_in = 0; op_valid = 0; mem_ack = 0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset_in = 1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_stall", 32'(stall), 32'(e.stall));
            chk("sb_bus_assert", 32'(bus_assert_oh), 32'(e.ba));
            chk("sb_bus_load", 32'(bus_load_oh), 32'(e.bl));
            chk("sb_xfer_assert", 32'(xfer_assert_oh), 32'(e.xa));
            chk("sb_xfer_load", 32'(xfer_load_oh), 32'(e.xl));
            chk("sb_addr", 32'(addr_oh), 32'(e.ad));
            chk("sb_mem_dir", 32'(mem_dir), 32'(e.dir));
            chk("sb_timeout_err", 32'(timeout_err), 32'(e.terr));
            chk("sb_contention_err", 32'(contention_err), 32'(e.cerr));
`ifdef MAINBUS_WAITSTAT_EN
            chk("sb_last_wait", 32'(last_wait_cycles), 32'(e.last));
            chk("sb_hist", 32'(wait_hist_sat), 32'(e.hist));
`endif
        end
    end

    function automatic int pick_dev();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r < 3) return 8;
        return int'($urandom_range(1, 15));
    endfunction

    initial begin
        reset_in = 0; op_valid = 0; mem_ack = 0;
        bus_assert_sel = 0; bus_load_sel = 0;
        xfer_assert_sel = 0; xfer_load_sel = 0; addr_sel = 0;
        model_reset();
        #23;
        chk_all_zero("reset");
        @(posedge clk);
        #2;
        reset_in = 1;

        // Simple register-to-register op with latency 1.
        drive(1, 2, 5, 0, 0, 0, 0);
        idle(0); look();
        chk("p1_bus_assert", 32'(bus_assert_oh), 32'h0004);
        chk("p1_bus_load", 32'(bus_load_oh), 32'h0020);
        chk("p1_stall", 32'(stall), 0);
        idle(0); look();
        chk("p1_cleared", 32'(bus_assert_oh | bus_load_oh), 0);

        // Memory read acked on the fourth held cycle.
        drive(1, 8, 0, 0, 0, 0, 0);
        idle(0); look();
        chk("p2_stall_hi", 32'(stall), 1);
        chk("p2_mem_dir", 32'(mem_dir), 1);
        idle(0); idle(0);
        idle(1); look();
        chk("p2_ack_stall", 32'(stall), 0);
        chk("p2_held", 32'(bus_assert_oh), 32'h0100);
        idle(0); look();
        chk("p2_exit", 32'(bus_assert_oh), 0);
`ifdef MAINBUS_WAITSTAT_EN
        chk("p2_last_wait", 32'(last_wait_cycles), 3);
`endif

        // Memory write that never gets an ack.
        drive(1, 0, 8, 0, 0, 0, 0);
        repeat (15) idle(0);
        look();
        chk("p3_stall_15", 32'(stall), 1);
        idle(0); look();
        chk("p3_timeout_stall", 32'(stall), 0);
        chk("p3_terr_pending", 32'(timeout_err), 0);
        idle(0); look();
        chk("p3_timeout_err", 32'(timeout_err), 1);
        chk("p3_cleared", 32'(bus_load_oh), 0);
`ifdef MAINBUS_WAITSTAT_EN
        chk("p3_last_wait", 32'(last_wait_cycles), 15);
        chk("p3_hist", 32'(wait_hist_sat), 1);
`endif

        // Self-transfer contention is dropped and latched.
        drive(1, 3, 3, 2, 0, 1, 0);
        drive(1, 2, 5, 0, 0, 0, 0); look();
        chk("p4_dropped", 32'(|{bus_assert_oh, bus_load_oh, xfer_assert_oh, addr_oh}), 0);
        chk("p4_cerr", 32'(contention_err), 1);
        idle(0); look();
        chk("p4_cerr_sticky", 32'(contention_err), 1);
        chk("p4_legal_op", 32'(bus_load_oh), 32'h0020);

        // New op accepted on the ack cycle.
        drive(1, 8, 4, 0, 0, 0, 0);
        idle(0);
        drive(1, 0, 0, 1, 0, 4, 1); look();
        chk("p5_ack_accept", 32'(stall), 0);
        idle(0); look();
        chk("p5_xfer_assert", 32'(xfer_assert_oh), 32'h02);
        chk("p5_addr", 32'(addr_oh), 32'h10);
        chk("p5_bus_clear", 32'(bus_assert_oh), 0);

        // Reset while waiting.
        drive(1, 8, 0, 0, 0, 0, 0);
        idle(0); idle(0);
        async_reset();
        idle(0); look();
        chk_all_zero("post_rst");

        // Randomised traffic: frequent acks, then rare acks to force timeouts.
        for (int i = 0; i < 900; i++) begin
            int ba, bl, xa, xl, ad, ack_pct;
            ack_pct = (i < 450) ? 35 : 3;
            ba = pick_dev();
            bl = ($urandom_range(0, 11) == 0) ? ba : pick_dev();
            xa = int'($urandom_range(0, 7));
            xl = ($urandom_range(0, 7) == 0) ? xa : int'($urandom_range(0, 7));
            ad = int'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 7, ba, bl, xa, xl, ad,
                  int'($urandom_range(0, 99)) < ack_pct);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
